freq_synth_loader: RTL and testbench

Bus master that programs the frequency synthesizer after power-up and on request. It writes the DCM frequency-synthesis DRP register, optionally reads it back to check it, then writes the synthesizer control register to select the fast or slow PLL output and to enable the generated clock. It is the initiator on the synthesizer's slave port, sits in the always-on `clk_from_ibufg` domain, and reports `done`/`error` to the board-level reset and status logic.

---
 rtl/freq_synth_loader_pkg.sv | 57 +++++
 rtl/bus_if.sv | 27 ++
 rtl/freq_synth_loader_bus_master_txn.sv | 124 ++++++++++++
 rtl/freq_synth_loader.sv | 155 +++++++++++++++
 tb/tb_freq_synth_loader.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_synth_loader_pkg.sv
// Freq_synth_pkg: types and constants shared by the frequency synthesizer
// loader (bus master) and the Freq_synth slave.
//   - bus command/response encodings and bus widths
//   - Control_reg layout of the synthesizer control register
//   - DRP address/data types and the default DFS M/D register address
//   - loader and transaction-engine state encodings
package Freq_synth_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  // Address bit that selects the control-register space over the DRP space.
  localparam int REG_SPACE_BIT = 16;

  typedef logic [6:0]  Drp_addr;
  typedef logic [15:0] Drp_data;

  localparam Drp_addr DRP_FX_ADDR_DEFAULT = 7'h50;

  typedef struct packed {
    logic [29:0] dummy;
    logic        sel_fast;
    logic        en_gen_clk;
  } Control_reg;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'd0,
    MCMD_WR   = 3'd1,
    MCMD_RD   = 3'd2
  } Mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'd0,
    SRESP_DVA  = 2'd1,
    SRESP_ERR  = 2'd3
  } Sresp_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_CMD,
    T_RESP
  } Txn_state_e;

  typedef enum logic [2:0] {
    S_STARTUP,
    S_WR_DRP,
    S_RD_DRP,
    S_WR_CREG,
    S_DONE,
    S_ERROR
  } Loader_state_e;

  // DFS register holds (M-1) in the upper byte and (D-1) in the lower byte.
  function automatic Drp_data drp_fx_word(input int m, input int d);
    return {8'(m - 1), 8'(d - 1)};
  endfunction

endpackage

// File: rtl/bus_if.sv
// Bus_if: point-to-point command/response bus between an initiator (master)
// and the synthesizer slave port.
//   master drives MCmd, MAddr, MData, MRespAccept
//   slave  drives SCmdAccept, SDataAccept, SResp, SData
interface Bus_if;
  import Freq_synth_pkg::*;

  Mcmd_e             MCmd;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MData;
  logic              MRespAccept;
  logic              SCmdAccept;
  logic              SDataAccept;
  Sresp_e            SResp;
  logic [DATA_W-1:0] SData;

  modport master (
    output MCmd, MAddr, MData, MRespAccept,
    input  SCmdAccept, SDataAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MRespAccept,
    output SCmdAccept, SDataAccept, SResp, SData
  );

endinterface

// File: rtl/freq_synth_loader_bus_master_txn.sv
// bus_master_txn: single-transaction bus engine.
// A one-cycle start captures cmd/addr/wdata into the registered bus outputs.
// The command is held until SCmdAccept, then MRespAccept is held until
// SResp=DVA. Each phase has its own timeout of TIMEOUT_CYCLES cycles.
// Ports:
//   clk_from_ibufg, resetb_pin (async, active-low)
//   start, cmd, addr, wdata    : transaction request from the sequencer
//   done, rdata, timeout       : completion in the DVA cycle / phase expiry
//   busy                       : registered, a transaction is in flight
//   mcmd, maddr, mdata, mrespaccept : registered bus outputs
//   scmdaccept, sresp, sdata   : bus inputs
module bus_master_txn
  import Freq_synth_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_from_ibufg,
  input  logic              resetb_pin,
  input  logic              start,
  input  Mcmd_e             cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              timeout,
  output logic              busy,
  output Mcmd_e             mcmd,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mdata,
  output logic              mrespaccept,
  input  logic              scmdaccept,
  input  Sresp_e            sresp,
  input  logic [DATA_W-1:0] sdata
);

  Txn_state_e        tstate, tstate_next;
  logic [31:0]       cnt, cnt_next;
  Mcmd_e             mcmd_next;
  logic [ADDR_W-1:0] maddr_next;
  logic [DATA_W-1:0] mdata_next;
  logic              racc_next;

  // Read data is only meaningful in the cycle that done is high.
  assign rdata = sdata;

  // All bus outputs are computed here and registered below. The cycle
  // counter restarts at issue and again at accept, so each phase gets its
  // own full timeout budget.
  always_comb begin
    tstate_next = tstate;
    cnt_next    = cnt;
    mcmd_next   = mcmd;
    maddr_next  = maddr;
    mdata_next  = mdata;
    racc_next   = mrespaccept;
    done        = 1'b0;
    timeout     = 1'b0;
    case (tstate)
      T_IDLE: begin
        if (start) begin
          tstate_next = T_CMD;
          mcmd_next   = cmd;
          maddr_next  = addr;
          mdata_next  = wdata;
          cnt_next    = '0;
        end
      end
      T_CMD: begin
        if (scmdaccept) begin
          tstate_next = T_RESP;
          mcmd_next   = MCMD_IDLE;
          racc_next   = 1'b1;
          cnt_next    = '0;
        end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout     = 1'b1;
          tstate_next = T_IDLE;
          mcmd_next   = MCMD_IDLE;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      T_RESP: begin
        // Anything other than DVA (including NULL) is a wait.
        if (sresp == SRESP_DVA) begin
          done        = 1'b1;
          tstate_next = T_IDLE;
          racc_next   = 1'b0;
        end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          timeout     = 1'b1;
          tstate_next = T_IDLE;
          racc_next   = 1'b0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: begin
        tstate_next = T_IDLE;
        mcmd_next   = MCMD_IDLE;
        racc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_from_ibufg or negedge resetb_pin) begin
    if (!resetb_pin) begin
      tstate      <= T_IDLE;
      cnt         <= '0;
      mcmd        <= MCMD_IDLE;
      maddr       <= '0;
      mdata       <= '0;
      mrespaccept <= 1'b0;
      busy        <= 1'b0;
    end else begin
      tstate      <= tstate_next;
      cnt         <= cnt_next;
      mcmd        <= mcmd_next;
      maddr       <= maddr_next;
      mdata       <= mdata_next;
      mrespaccept <= racc_next;
      busy        <= (tstate_next != T_IDLE);
    end
  end

endmodule

// File: rtl/freq_synth_loader.sv
// freq_synth_loader: programs the DCM CLKFX M/D DRP register after reset,
// optionally reads it back, then writes the synthesizer control register
// (PLL select + clock enable). Rewrites the control register whenever
// sel_fast changes while programming is complete.
// Ports:
//   clk_from_ibufg, resetb_pin (async, active-low)
//   sel_fast : requested PLL output, level-sensitive (1 = fast)
//   bus      : Bus_if.master initiator port to the synthesizer slave
//   done     : programming complete, generated clock enabled
//   error    : sticky, timeout or read-back mismatch
//   busy     : a bus transaction is in flight
// Build option: FREQ_SYNTH_LOADER_VERIFY_EN adds a DRP read-back check.
module freq_synth_loader
  import Freq_synth_pkg::*;
#(
  parameter int      DCM_M          = 2,
  parameter int      DCM_D          = 5,
  parameter Drp_addr DRP_FX_ADDR    = DRP_FX_ADDR_DEFAULT,
  parameter int      STARTUP_CYCLES = 64,
  parameter int      TIMEOUT_CYCLES = 256
) (
  input  logic  clk_from_ibufg,
  input  logic  resetb_pin,
  input  logic  sel_fast,
  Bus_if.master bus,
  output logic  done,
  output logic  error,
  output logic  busy
);

  localparam Drp_data           DRP_WORD  = drp_fx_word(DCM_M, DCM_D);
  localparam logic [ADDR_W-1:0] DRP_ADDR  = ADDR_W'(DRP_FX_ADDR);
  localparam logic [ADDR_W-1:0] CREG_ADDR = ADDR_W'(1) << REG_SPACE_BIT;

  Loader_state_e     state, next_state;
  logic [31:0]       startup_cnt;
  logic              launched;
  logic              last_sel;
  logic              txn_start;
  Mcmd_e             txn_cmd;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic              txn_done;
  logic              txn_timeout;
  logic [DATA_W-1:0] txn_rdata;
  Control_reg        ctrl_word;

  // SDataAccept has no role for single-beat writes; read data is only
  // consumed by the optional read-back.
  logic unused_bus_inputs;
  assign unused_bus_inputs = ^{bus.SDataAccept, txn_rdata};

  bus_master_txn #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_txn (
    .clk_from_ibufg(clk_from_ibufg),
    .resetb_pin    (resetb_pin),
    .start         (txn_start),
    .cmd           (txn_cmd),
    .addr          (txn_addr),
    .wdata         (txn_wdata),
    .done          (txn_done),
    .rdata         (txn_rdata),
    .timeout       (txn_timeout),
    .busy          (busy),
    .mcmd          (bus.MCmd),
    .maddr         (bus.MAddr),
    .mdata         (bus.MData),
    .mrespaccept   (bus.MRespAccept),
    .scmdaccept    (bus.SCmdAccept),
    .sresp         (bus.SResp),
    .sdata         (bus.SData)
  );

  // Each bus state launches exactly one transaction on entry (launched
  // blocks a relaunch) and leaves in the cycle the engine reports done or
  // timeout, so the next state's command follows one cycle later.
  always_comb begin
    next_state           = state;
    txn_start            = 1'b0;
    txn_cmd              = MCMD_WR;
    txn_addr             = DRP_ADDR;
    txn_wdata            = DATA_W'(DRP_WORD);
    ctrl_word            = '0;
    ctrl_word.sel_fast   = sel_fast;
    ctrl_word.en_gen_clk = 1'b1;
    case (state)
      S_STARTUP: begin
        if (startup_cnt == 32'(STARTUP_CYCLES - 1)) next_state = S_WR_DRP;
      end
      S_WR_DRP: begin
        txn_start = !launched;
        if (txn_timeout) begin
          next_state = S_ERROR;
        end else if (txn_done) begin
`ifdef FREQ_SYNTH_LOADER_VERIFY_EN
          next_state = S_RD_DRP;
`else
          next_state = S_WR_CREG;
`endif
        end
      end
      S_RD_DRP: begin
        txn_cmd   = MCMD_RD;
        txn_start = !launched;
        if (txn_timeout) begin
          next_state = S_ERROR;
        end else if (txn_done) begin
`ifdef FREQ_SYNTH_LOADER_VERIFY_EN
          next_state = (txn_rdata[15:0] == DRP_WORD) ? S_WR_CREG : S_ERROR;
`else
          next_state = S_WR_CREG;
`endif
        end
      end
      S_WR_CREG: begin
        txn_addr  = CREG_ADDR;
        txn_wdata = ctrl_word;
        txn_start = !launched;
        if (txn_timeout)   next_state = S_ERROR;
        else if (txn_done) next_state = S_DONE;
      end
      S_DONE: begin
        // Also catches a toggle that happened while the write was in flight.
        if (sel_fast != last_sel) next_state = S_WR_CREG;
      end
      S_ERROR: begin
        next_state = S_ERROR;
      end
      default: begin
        next_state = S_ERROR;
      end
    endcase
  end

  // last_sel records the select value actually issued in the control write.
  always_ff @(posedge clk_from_ibufg or negedge resetb_pin) begin
    if (!resetb_pin) begin
      state       <= S_STARTUP;
      startup_cnt <= '0;
      launched    <= 1'b0;
      last_sel    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_STARTUP) startup_cnt <= startup_cnt + 32'd1;
      launched <= (next_state == state) && (launched || txn_start);
      if (txn_start && (state == S_WR_CREG)) last_sel <= sel_fast;
      done  <= (next_state == S_DONE);
      error <= error || (next_state == S_ERROR);
    end
  end

endmodule

// File: tb/tb_freq_synth_loader.sv
// tb_freq_synth_loader: randomized self-checking bench for freq_synth_loader.
// A behavioural slave with random accept/response latency records every
// accepted command; the expected command list is built from the programming
// rules (boot writes, one control write per select change).
module tb_freq_synth_loader;
  import Freq_synth_pkg::*;

  localparam int          STARTUP   = 64;
  localparam int          TIMEOUT   = 256;
  localparam int          DCM_M_TB  = 2;
  localparam int          DCM_D_TB  = 5;
  localparam logic [31:0] DRP_ADDR  = 32'h0000_0050;
  localparam logic [31:0] CREG_ADDR = 32'h0000_0001 << 16;
  localparam logic [31:0] DRP_WORD  = ((DCM_M_TB - 1) << 8) | (DCM_D_TB - 1);

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } Txn_t;

  logic clk_from_ibufg = 1'b0;
  logic resetb_pin;
  logic sel_fast;
  logic done, error, busy;

  Bus_if bus();

  int   checks = 0;
  int   errors = 0;
  Txn_t gotQ[$];
  Txn_t expQ[$];
  int   accDelay, respDelay, slPhase, slWait;
  bit   neverAccept, neverRespond, rdGood;

  freq_synth_loader dut (
    .clk_from_ibufg(clk_from_ibufg),
    .resetb_pin    (resetb_pin),
    .sel_fast      (sel_fast),
    .bus           (bus),
    .done          (done),
    .error         (error),
    .busy          (busy)
  );

  always #5 clk_from_ibufg = ~clk_from_ibufg;

  // Behavioural slave: accepts after accDelay cycles, answers DVA after
  // respDelay cycles; drives on the falling edge.
  always @(negedge clk_from_ibufg) begin
    Txn_t t;
    if (!resetb_pin) begin
      slPhase = 0;
      slWait = 0;
      bus.SCmdAccept = 1'b0;
      bus.SResp = SRESP_NULL;
      bus.SData = '0;
    end else begin
      case (slPhase)
        0: begin
          if (bus.MCmd != MCMD_IDLE) begin
            if (!neverAccept && slWait >= accDelay) begin
              bus.SCmdAccept = 1'b1;
              t.cmd = bus.MCmd;
              t.addr = bus.MAddr;
              t.data = bus.MData;
              gotQ.push_back(t);
              slPhase = 1;
              slWait = 0;
            end else begin
              slWait++;
            end
          end
        end
        1: begin
          bus.SCmdAccept = 1'b0;
          if (!neverRespond && slWait >= respDelay) begin
            bus.SResp = SRESP_DVA;
            bus.SData = rdGood ? (($urandom & 32'hFFFF_0000) | DRP_WORD) : 32'h0000_0105;
            slPhase = 2;
          end else begin
            slWait++;
          end
        end
        default: begin
          bus.SResp = SRESP_NULL;
          bus.SData = $urandom;
          slPhase = 0;
          slWait = 0;
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
    Txn_t t;
    t.cmd = 3'd1;
    t.addr = addr;
    t.data = data;
    expQ.push_back(t);
  endtask

  // Boot sequence: DRP write, optional read-back, control write.
  task automatic expectBoot(input bit sel);
    Txn_t t;
    expectWrite(DRP_ADDR, DRP_WORD);
`ifdef FREQ_SYNTH_LOADER_VERIFY_EN
    t.cmd = 3'd2;
    t.addr = DRP_ADDR;
    t.data = DRP_WORD;
    expQ.push_back(t);
`endif
    expectWrite(CREG_ADDR, {30'b0, sel, 1'b1});
  endtask

  task automatic compareTxns(input string tag);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      checkOutput($sformatf("%s_cmd%0d", tag, i), gotQ[i].cmd, expQ[i].cmd);
      checkOutput($sformatf("%s_addr%0d", tag, i), gotQ[i].addr, expQ[i].addr);
      if (expQ[i].cmd == 3'd1)
        checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i].data, expQ[i].data);
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic applyStimulus(input int acc, input int resp, input bit sel, input bit nAcc, input bit nResp);
    @(negedge clk_from_ibufg);
    resetb_pin = 1'b0;
    sel_fast = sel;
    accDelay = acc;
    respDelay = resp;
    neverAccept = nAcc;
    neverRespond = nResp;
    repeat (2) @(negedge clk_from_ibufg);
    gotQ.delete();
    expQ.delete();
    resetb_pin = 1'b1;
  endtask

  task automatic waitDone(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput({tag, "_done"}, done, 1'b1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mcmd"}, bus.MCmd, MCMD_IDLE);
    checkOutput({tag, "_maddr"}, bus.MAddr, 0);
    checkOutput({tag, "_mdata"}, bus.MData, 0);
    checkOutput({tag, "_racc"}, bus.MRespAccept, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Change sel_fast in S_DONE; optionally flip it back while the control
  // write is in flight, which must cause a second write.
  task automatic toggleTest(input string tag, input bit pingPong);
    int n;
    sel_fast = ~sel_fast;
    expectWrite(CREG_ADDR, {30'b0, sel_fast, 1'b1});
    @(negedge clk_from_ibufg);
    checkOutput({tag, "_done_drop"}, done, 0);
    if (pingPong) begin
      n = 0;
      while (busy !== 1'b1 && n < 50) begin
        @(negedge clk_from_ibufg);
        n++;
      end
      checkOutput({tag, "_busy"}, busy, 1);
      sel_fast = ~sel_fast;
      expectWrite(CREG_ADDR, {30'b0, sel_fast, 1'b1});
    end
    repeat (40) @(negedge clk_from_ibufg);
    checkOutput({tag, "_done_back"}, done, 1);
    checkOutput({tag, "_error"}, error, 0);
    compareTxns(tag);
  endtask

  initial begin
    int n;
    bit sel;
    resetb_pin = 1'b0;
    sel_fast = 1'b1;
    accDelay = 0;
    respDelay = 0;
    neverAccept = 1'b0;
    neverRespond = 1'b0;
`ifdef FREQ_SYNTH_LOADER_VERIFY_EN
    rdGood = 1'b1;
`else
    rdGood = 1'b0;
`endif
    bus.SDataAccept = 1'b1;
    repeat (2) @(negedge clk_from_ibufg);
    checkResetValues("rst");

    // Immediate-accept slave, sel_fast=1.
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b0);
    expectBoot(1'b1);
    waitDone("boot", 300, n);
    checkOutput("boot_latency", (n >= STARTUP + 3) && (n <= STARTUP + 12), 1);
    checkOutput("boot_error", error, 0);
    checkOutput("boot_busy", busy, 0);
    compareTxns("boot");
    toggleTest("tog10", 1'b0);

    // Randomized latencies, select values and runtime toggles.
    for (int it = 0; it < 6; it++) begin
      sel = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 4), $urandom_range(0, 4), sel, 1'b0, 1'b0);
      expectBoot(sel);
      waitDone($sformatf("rnd%0d", it), 400, n);
      checkOutput($sformatf("rnd%0d_error", it), error, 0);
      compareTxns($sformatf("rnd%0d", it));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        toggleTest($sformatf("rnd%0d_tog%0d", it, k), 1'($urandom_range(0, 1)));
    end

    // Command never accepted.
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (bus.MCmd == MCMD_IDLE && n < 200) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("toacc_issue", bus.MCmd, MCMD_WR);
    n = 0;
    while (error !== 1'b1 && n < 2 * TIMEOUT) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("toacc_cycles", n, TIMEOUT);
    checkOutput("toacc_mcmd", bus.MCmd, MCMD_IDLE);
    checkOutput("toacc_busy", busy, 0);
    checkOutput("toacc_done", done, 0);
    repeat (5) @(negedge clk_from_ibufg);
    checkOutput("toacc_sticky", error, 1);
    checkOutput("toacc_txns", gotQ.size(), 0);

    // Command accepted, response never arrives.
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (bus.MRespAccept !== 1'b1 && n < 200) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("toresp_racc", bus.MRespAccept, 1);
    n = 0;
    while (error !== 1'b1 && n < 2 * TIMEOUT) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("toresp_cycles", n, TIMEOUT);
    checkOutput("toresp_racc_low", bus.MRespAccept, 0);
    checkOutput("toresp_done", done, 0);

`ifdef FREQ_SYNTH_LOADER_VERIFY_EN
    // Read-back returns the wrong word: error, no control write.
    rdGood = 1'b0;
    applyStimulus(1, 1, 1'b1, 1'b0, 1'b0);
    expectWrite(DRP_ADDR, DRP_WORD);
    expectWrite(DRP_ADDR, DRP_WORD);
    expQ[1].cmd = 3'd2;
    n = 0;
    while (error !== 1'b1 && n < 300) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("mism_error", error, 1);
    repeat (20) @(negedge clk_from_ibufg);
    checkOutput("mism_done", done, 0);
    compareTxns("mism");
    rdGood = 1'b1;
`endif

    // Asynchronous reset in the middle of a response phase.
    applyStimulus(1, 12, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.MRespAccept !== 1'b1 && n < 200) begin
      @(negedge clk_from_ibufg);
      n++;
    end
    checkOutput("midrst_racc", bus.MRespAccept, 1);
    #2;
    resetb_pin = 1'b0;
    #1;
    checkResetValues("midrst");
    repeat (2) @(negedge clk_from_ibufg);
    gotQ.delete();
    expQ.delete();
    resetb_pin = 1'b1;
    expectBoot(1'b0);
    waitDone("midrst_reboot", 400, n);
    checkOutput("midrst_error", error, 0);
    compareTxns("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
